// File: rtl/router_port_reader.sv
// Drains one router output port one packet at a time, checks the trailing parity byte and
// forwards every byte on a valid/ready stream with last/err sidebands and packet/error counters.
module router_port_reader #(
  parameter int unsigned STALL_LIMIT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             vld_out,
  input  logic [7:0]       data_out,
  output logic             read_enb,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             m_err,
  output logic [1:0]       m_addr,
  output logic             pkt_abort,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);
  localparam int unsigned REM_W   = 7;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HDR_W  = 2'd1;
  localparam logic [1:0] S_BODY   = 2'd2;
  localparam logic [1:0] S_LAST_W = 2'd3;

  logic [1:0]         r_state,   w_state_n;
  logic [REM_W-1:0]   r_rem,     w_rem_n;
  logic [7:0]         r_par,     w_par_n;
  logic [1:0]         r_addr,    w_addr_n;
  logic [STALL_W-1:0] r_stall,   w_stall_n;
  logic               r_abort,   w_abort_n;
  logic [CNT_W-1:0]   r_pkt_cnt, w_pkt_n;
  logic [CNT_W-1:0]   r_err_cnt, w_errc_n;
  logic               r_rd_q;
  logic               r_en;

  // two-entry skid buffer between port capture and the byte stream
  logic [7:0] r_buf_data [2];
  logic       r_buf_last [2];
  logic       r_buf_err  [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_occ;

  logic       w_pop;
  logic       w_push;
  logic       w_push_last;
  logic       w_push_err;
  logic [2:0] w_occ_after;
  logic       w_rd_state;
  logic       w_abort;
  logic       w_read_enb;

  assign m_valid     = (r_occ != 2'd0);
  assign m_data      = r_buf_data[r_rd_ptr];
  assign m_last      = r_buf_last[r_rd_ptr];
  assign m_err       = r_buf_err[r_rd_ptr];
  assign m_addr      = r_addr;
  assign pkt_abort   = r_abort;
  assign pkt_cnt     = r_pkt_cnt;
  assign err_cnt     = r_err_cnt;

  assign w_pop       = m_valid & m_ready;
  assign w_push      = r_rd_q;
  assign w_push_last = (r_state == S_LAST_W);
  assign w_push_err  = (r_state == S_LAST_W) & (data_out != r_par);
  assign w_occ_after = 3'(r_occ) + 3'(r_rd_q) - 3'(w_pop);
  assign w_rd_state  = (r_state == S_IDLE) | (r_state == S_BODY);
  assign w_abort     = ((r_state == S_BODY) | (r_state == S_LAST_W)) &
                       (r_stall == STALL_W'(STALL_LIMIT));
  // r_en keeps the port quiet during and for one cycle after reset
  assign w_read_enb  = r_en & vld_out & w_rd_state & !w_abort & (w_occ_after < 3'd2);
  assign read_enb    = w_read_enb;

  // state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_n;
  end

  // next-state and packet bookkeeping
  always_comb begin
    w_state_n = r_state;
    w_rem_n   = r_rem;
    w_par_n   = r_par;
    w_addr_n  = r_addr;
    w_stall_n = r_stall;
    w_abort_n = 1'b0;
    w_pkt_n   = r_pkt_cnt;
    w_errc_n  = r_err_cnt;
    case (r_state)
      S_IDLE: begin
        w_stall_n = '0;
        if (w_read_enb) w_state_n = S_HDR_W;
      end
      S_HDR_W: begin
        if (r_rd_q) begin
          w_rem_n   = REM_W'(data_out[7:2]) + REM_W'(1);
          w_par_n   = data_out;
          w_addr_n  = data_out[1:0];
          w_stall_n = '0;
          w_state_n = S_BODY;
        end
      end
      S_BODY: begin
        if (w_abort) begin
          w_abort_n = 1'b1;
          w_stall_n = '0;
          w_state_n = S_IDLE;
        end else begin
          if (r_rd_q) w_par_n = r_par ^ data_out;
          if (w_read_enb) begin
            w_rem_n   = r_rem - REM_W'(1);
            w_stall_n = '0;
            if (r_rem == REM_W'(1)) w_state_n = S_LAST_W;
          end else if (!vld_out && !r_rd_q) begin
            w_stall_n = r_stall + STALL_W'(1);
          end
        end
      end
      S_LAST_W: begin
        if (w_abort) begin
          w_abort_n = 1'b1;
          w_stall_n = '0;
          w_state_n = S_IDLE;
        end else if (r_rd_q) begin
          if (r_pkt_cnt != {CNT_W{1'b1}}) w_pkt_n = r_pkt_cnt + CNT_W'(1);
          if (w_push_err && (r_err_cnt != {CNT_W{1'b1}})) w_errc_n = r_err_cnt + CNT_W'(1);
          w_stall_n = '0;
          w_state_n = S_IDLE;
        end else if (!vld_out) begin
          w_stall_n = r_stall + STALL_W'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rem     <= '0;
      r_par     <= '0;
      r_addr    <= '0;
      r_stall   <= '0;
      r_abort   <= 1'b0;
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
      r_rd_q    <= 1'b0;
      r_en      <= 1'b0;
    end else begin
      r_rem     <= w_rem_n;
      r_par     <= w_par_n;
      r_addr    <= w_addr_n;
      r_stall   <= w_stall_n;
      r_abort   <= w_abort_n;
      r_pkt_cnt <= w_pkt_n;
      r_err_cnt <= w_errc_n;
      r_rd_q    <= w_read_enb;
      r_en      <= 1'b1;
    end
  end

  // sidebands are stored with the byte so they leave with it, not with FSM state
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_last[i] <= 1'b0;
        r_buf_err[i]  <= 1'b0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= data_out;
        r_buf_last[r_wr_ptr] <= w_push_last;
        r_buf_err[r_wr_ptr]  <= w_push_err;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= 2'(w_occ_after);
    end
  end

endmodule

// File: tb/tb_router_port_reader.sv
// Directed bench for router_port_reader: a queue models the router port FIFO and a
// scoreboard of expected beats is checked as the sink accepts bytes.
module tb_router_port_reader;

  localparam int unsigned CNT_W = 16;

  logic             clock    = 1'b0;
  logic             resetn   = 1'b0;
  logic             vld_out  = 1'b0;
  logic [7:0]       data_out = 8'h00;
  logic             m_ready  = 1'b1;
  logic             read_enb;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_err;
  logic [1:0]       m_addr;
  logic             pkt_abort;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] err_cnt;

  typedef struct packed {
    logic [1:0] addr;
    logic       err;
    logic       last;
    logic [7:0] data;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] fifo_q[$];

  int   n_cmp     = 0;
  int   n_err     = 0;
  int   n_last    = 0;
  int   n_abort   = 0;
  int   cyc       = 0;
  int   rdy_mode  = 0;
  int   exp_pkt   = 0;
  int   exp_errc  = 0;
  logic prev_stall = 1'b0;
  logic [9:0] prev_beat = '0;

  router_port_reader #(.STALL_LIMIT(64), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .vld_out   (vld_out),
    .data_out  (data_out),
    .read_enb  (read_enb),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .m_err     (m_err),
    .m_addr    (m_addr),
    .pkt_abort (pkt_abort),
    .pkt_cnt   (pkt_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // router port FIFO: data appears the cycle after read_enb
  always @(posedge clock) begin
    if (read_enb && fifo_q.size() != 0) data_out <= fifo_q.pop_front();
  end

  // sink, port flags and scoreboard
  always @(negedge clock) begin
    beat_t e;
    cyc++;
    if (read_enb) check("read_while_empty", 32'(vld_out), 32'd1);
    vld_out = (fifo_q.size() != 0);
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cyc % 3 == 0);
      default: m_ready = 1'b0;
    endcase
    if (prev_stall && resetn) check("stable_hold", 32'({m_data, m_last, m_err}), 32'(prev_beat));
    if (m_valid && m_ready) begin
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("m_data", 32'(m_data), 32'(e.data));
        check("m_last", 32'(m_last), 32'(e.last));
        check("m_err",  32'(m_err & m_last), 32'(e.err));
        if (e.last) begin
          n_last++;
          check("m_addr", 32'(m_addr), 32'(e.addr));
        end
      end
    end
    prev_stall = resetn && m_valid && !m_ready;
    prev_beat  = {m_data, m_last, m_err};
    if (pkt_abort) n_abort++;
  end

  // queue a packet into the port FIFO; n_load>0 loads only that many bytes (not counted as complete)
  task automatic load_pkt(input int len, input logic [1:0] addr, input logic [7:0] base,
                          input bit bad, input int n_load);
    logic [7:0] b;
    logic [7:0] par;
    beat_t      e;
    int         total;
    int         lim;
    total = len + 2;
    lim   = (n_load == 0) ? total : n_load;
    par   = {6'(len), addr};
    for (int i = 0; i < total; i++) begin
      if (i == 0) b = {6'(len), addr};
      else if (i <= len) begin
        b   = base + 8'(i - 1) * 8'h11;
        par = par ^ b;
      end else b = bad ? (par ^ 8'h01) : par;
      if (i < lim) begin
        fifo_q.push_back(b);
        e.data = b;
        e.last = (i == total - 1);
        e.err  = e.last & bad;
        e.addr = addr;
        exp_q.push_back(e);
      end
    end
    if (n_load == 0) begin
      exp_pkt++;
      if (bad) exp_errc++;
    end
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && k < 2000) begin
      @(negedge clock);
      k++;
    end
    repeat (4) @(negedge clock);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_pkt));
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_errc));
  endtask

  initial begin
    int k;
    #1;
    check("rst_read_enb", 32'(read_enb), 32'd0);
    check("rst_m_valid",  32'(m_valid),  32'd0);
    check("rst_m_data",   32'(m_data),   32'd0);
    check("rst_pkt_cnt",  32'(pkt_cnt),  32'd0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // good packet, len 3 addr 1
    load_pkt(3, 2'd1, 8'h11, 1'b0, 0);
    wait_drain("good_len3");

    // same packet with a corrupted parity byte
    load_pkt(3, 2'd1, 8'h11, 1'b1, 0);
    wait_drain("bad_parity");

    // back-pressure: ready one cycle in three
    rdy_mode = 1;
    load_pkt(20, 2'd2, 8'h05, 1'b0, 0);
    wait_drain("throttled_len20");
    rdy_mode = 0;

    // two packets queued back to back, including len=0
    load_pkt(5, 2'd3, 8'h3C, 1'b0, 0);
    load_pkt(0, 2'd0, 8'h00, 1'b0, 0);
    wait_drain("back_to_back");
    check("lasts_after_b2b", 32'(n_last), 32'd5);

    // port runs dry mid-packet: expect one abort pulse and no completion
    load_pkt(10, 2'd0, 8'h21, 1'b0, 3);
    k = 0;
    while (n_abort == 0 && k < 300) begin
      @(negedge clock);
      k++;
    end
    repeat (10) @(negedge clock);
    check("abort_pulses", 32'(n_abort), 32'd1);
    wait_drain("stall_abort");
    check("lasts_after_abort", 32'(n_last), 32'd5);

    // async reset in the middle of a blocked packet
    rdy_mode = 2;
    load_pkt(10, 2'd2, 8'h40, 1'b0, 12);
    repeat (10) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("arst_read_enb",  32'(read_enb),  32'd0);
    check("arst_m_valid",   32'(m_valid),   32'd0);
    check("arst_m_last",    32'(m_last),    32'd0);
    check("arst_m_err",     32'(m_err),     32'd0);
    check("arst_pkt_abort", 32'(pkt_abort), 32'd0);
    check("arst_m_data",    32'(m_data),    32'd0);
    check("arst_m_addr",    32'(m_addr),    32'd0);
    check("arst_pkt_cnt",   32'(pkt_cnt),   32'd0);
    check("arst_err_cnt",   32'(err_cnt),   32'd0);
    fifo_q.delete();
    exp_q.delete();
    exp_pkt  = 0;
    exp_errc = 0;
    rdy_mode = 0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    load_pkt(2, 2'd3, 8'h70, 1'b0, 0);
    wait_drain("after_reset");
    check("lasts_final", 32'(n_last), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
